// File: rtl/instr_decode_pkg.sv
// Shared types for the RV32I decode stage: op classes, immediate formats,
// fetched/decoded bundles and the opcode classifier.
package instr_decode_pkg;

  localparam int WORD_W = 32;
  localparam int IDX_W  = 5;

  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_OP_IMM = 5'b00100;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_JAL    = 5'b11011;
  localparam logic [4:0] OPC_SYSTEM = 5'b11100;

  // OP_NONE is zero so an illegal word decodes to op == 0.
  typedef enum logic [3:0] {
    OP_NONE      = 4'd0,
    INSTR_OP_IMM = 4'd1,
    INSTR_OP     = 4'd2,
    OP_LOAD      = 4'd3,
    OP_STORE     = 4'd4,
    OP_BRANCH    = 4'd5,
    OP_JAL       = 4'd6,
    OP_JALR      = 4'd7,
    OP_LUI       = 4'd8,
    OP_AUIPC     = 4'd9,
    OP_SYSTEM    = 4'd10
  } instr_op;

  typedef enum logic [2:0] {
    FMT_NONE, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_R
  } imm_fmt;

  typedef struct packed {
    logic [WORD_W-1:0] instr;
    logic [WORD_W-1:0] pc;
  } fetched_instr;

  typedef struct packed {
    instr_op           op;
    logic [IDX_W-1:0]  rd;
    logic [2:0]        funct3;
    logic [WORD_W-1:0] imm;
    logic [WORD_W-1:0] rs1_val;
    logic [WORD_W-1:0] rs2_val;
    logic [WORD_W-1:0] pc;
    logic              illegal;
  } decoded_instr;

  // Source indices ride along with a held entry so late write-backs can patch it.
  typedef struct packed {
    decoded_instr     d;
    logic [IDX_W-1:0] rs1_idx;
    logic [IDX_W-1:0] rs2_idx;
  } held_entry;

  typedef struct packed {
    instr_op op;
    imm_fmt  fmt;
  } op_class;

  function automatic op_class classify(input logic [WORD_W-1:0] instr);
    op_class c;
    c.op  = OP_NONE;
    c.fmt = FMT_NONE;
    if (instr[1:0] == 2'b11) begin
      case (instr[6:2])
        OPC_LOAD:   begin c.op = OP_LOAD;      c.fmt = FMT_I; end
        OPC_OP_IMM: begin c.op = INSTR_OP_IMM; c.fmt = FMT_I; end
        OPC_AUIPC:  begin c.op = OP_AUIPC;     c.fmt = FMT_U; end
        OPC_STORE:  begin c.op = OP_STORE;     c.fmt = FMT_S; end
        OPC_OP:     begin c.op = INSTR_OP;     c.fmt = FMT_R; end
        OPC_LUI:    begin c.op = OP_LUI;       c.fmt = FMT_U; end
        OPC_BRANCH: begin c.op = OP_BRANCH;    c.fmt = FMT_B; end
        OPC_JALR:   begin c.op = OP_JALR;      c.fmt = FMT_I; end
        OPC_JAL:    begin c.op = OP_JAL;       c.fmt = FMT_J; end
        OPC_SYSTEM: begin c.op = OP_SYSTEM;    c.fmt = FMT_I; end
        default:    ;
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/instr_decode_if.sv
// Decoupled channels into and out of the decode stage.
// Handshake: a beat transfers on a rising clk edge where valid && ready; once valid
// is raised it stays high and data stays put until that transfer (decoded data may
// only change through write-back operand bypass). ready may depend on valid.
interface fetched_if;
  logic                         valid;
  logic                         ready;
  instr_decode_pkg::fetched_instr data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

interface decoded_if;
  logic                         valid;
  logic                         ready;
  instr_decode_pkg::decoded_instr data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/instr_decode_imm_gen.sv
// Immediate generator: instruction word plus format select to a 32-bit immediate.
module instr_decode_imm_gen
  import instr_decode_pkg::*;
(
  input  logic [WORD_W-1:0] instr,
  input  imm_fmt            fmt,
  output logic [WORD_W-1:0] imm
);

  always_comb begin
    imm = '0;
    case (fmt)
      FMT_I: imm = {{20{instr[31]}}, instr[31:20]};
      FMT_S: imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B: imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U: imm = {instr[31:12], 12'b0};
      FMT_J: imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      // Zero-extended so imm[11:5] carries funct7 for the exec units.
      FMT_R: imm = {20'b0, instr[31:20]};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/instr_decode.sv
// RV32I decode stage: classifies, extracts fields and reads operands, holding the
// result on a decoupled output. Build option DECODE_SKID_EN adds a skid entry.
module instr_decode
  import instr_decode_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int REG_IDX_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  fetched_if.slave             fetched,
  decoded_if.master            decoded,
  output logic [REG_IDX_W-1:0] rf_rs1_idx,
  input  logic [XLEN-1:0]      rf_rs1_val,
  output logic [REG_IDX_W-1:0] rf_rs2_idx,
  input  logic [XLEN-1:0]      rf_rs2_val,
  input  logic                 wb_valid,
  input  logic [REG_IDX_W-1:0] wb_idx,
  input  logic [XLEN-1:0]      wb_val,
  input  logic                 flush
);

  logic [XLEN-1:0] word;
  op_class         cls;
  logic [XLEN-1:0] imm_raw;
  held_entry       incoming;
  held_entry       main_q;
  logic            main_valid_q;
  logic            accept;
  logic            out_fire;

  assign word       = fetched.data.instr;
  assign cls        = classify(word);
  assign rf_rs1_idx = word[19:15];
  assign rf_rs2_idx = word[24:20];

  instr_decode_imm_gen u_imm_gen (
    .instr (word),
    .fmt   (cls.fmt),
    .imm   (imm_raw)
  );

  // x0 always reads zero; a same-cycle write-back beats the stale regfile value.
  function automatic logic [XLEN-1:0] fwd(input logic [REG_IDX_W-1:0] idx,
                                          input logic [XLEN-1:0] cur);
    if (idx == '0) return '0;
    if (wb_valid && wb_idx == idx) return wb_val;
    return cur;
  endfunction

  function automatic held_entry hold(input held_entry e);
    held_entry r;
    r           = e;
    r.d.rs1_val = fwd(e.rs1_idx, e.d.rs1_val);
    r.d.rs2_val = fwd(e.rs2_idx, e.d.rs2_val);
    return r;
  endfunction

  always_comb begin
    incoming           = '0;
    incoming.rs1_idx   = word[19:15];
    incoming.rs2_idx   = word[24:20];
    incoming.d.illegal = (cls.op == OP_NONE);
    incoming.d.op      = cls.op;
    incoming.d.rd      = incoming.d.illegal ? '0 : word[11:7];
    incoming.d.funct3  = word[14:12];
    incoming.d.imm     = imm_raw;
    incoming.d.rs1_val = fwd(rf_rs1_idx, rf_rs1_val);
    incoming.d.rs2_val = fwd(rf_rs2_idx, rf_rs2_val);
    incoming.d.pc      = fetched.data.pc;
  end

  assign accept        = fetched.valid && fetched.ready;
  assign out_fire      = main_valid_q && decoded.ready;
  assign decoded.valid = main_valid_q;
  assign decoded.data  = main_q.d;

`ifdef DECODE_SKID_EN
  held_entry skid_q;
  logic      skid_valid_q;
  logic      ready_q;

  // ready_q mirrors "skid empty" one cycle ahead, so decoded.ready never reaches fetched.ready.
  assign fetched.ready = ready_q && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      main_q       <= '0;
      skid_valid_q <= 1'b0;
      skid_q       <= '0;
      ready_q      <= 1'b0;
    end else if (flush) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      ready_q      <= 1'b1;
    end else if (accept) begin
      if (!main_valid_q || out_fire) begin
        main_q       <= incoming;
        main_valid_q <= 1'b1;
        ready_q      <= 1'b1;
      end else begin
        skid_q       <= incoming;
        skid_valid_q <= 1'b1;
        main_q       <= hold(main_q);
        ready_q      <= 1'b0;
      end
    end else if (out_fire) begin
      if (skid_valid_q) begin
        main_q       <= hold(skid_q);
        skid_valid_q <= 1'b0;
      end else begin
        main_valid_q <= 1'b0;
      end
      ready_q <= 1'b1;
    end else begin
      if (main_valid_q) main_q <= hold(main_q);
      if (skid_valid_q) skid_q <= hold(skid_q);
      ready_q <= !skid_valid_q;
    end
  end
`else
  assign fetched.ready = !rst && !flush && (!main_valid_q || decoded.ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      main_q       <= '0;
    end else if (flush) begin
      main_valid_q <= 1'b0;
    end else if (accept) begin
      main_q       <= incoming;
      main_valid_q <= 1'b1;
    end else if (out_fire) begin
      main_valid_q <= 1'b0;
    end else if (main_valid_q) begin
      main_q <= hold(main_q);
    end
  end
`endif

endmodule

// File: tb/tb_instr_decode.sv
// Directed bench for instr_decode; inputs change on the falling edge, outputs are
// checked on the falling edge (or #1 after it).
module tb_instr_decode;
  import instr_decode_pkg::*;

  logic        clk;
  logic        rst;
  logic [4:0]  rf_rs1_idx;
  logic [31:0] rf_rs1_val;
  logic [4:0]  rf_rs2_idx;
  logic [31:0] rf_rs2_val;
  logic        wb_valid;
  logic [4:0]  wb_idx;
  logic [31:0] wb_val;
  logic        flush;
  logic [31:0] rf [32];
  logic [31:0] exp_q[$];
  logic [31:0] exp_v;
  int          checks = 0;
  int          errors = 0;
  int          sent;
  int          got;

  fetched_if fetched ();
  decoded_if decoded ();

  instr_decode dut (
    .clk        (clk),
    .rst        (rst),
    .fetched    (fetched),
    .decoded    (decoded),
    .rf_rs1_idx (rf_rs1_idx),
    .rf_rs1_val (rf_rs1_val),
    .rf_rs2_idx (rf_rs2_idx),
    .rf_rs2_val (rf_rs2_val),
    .wb_valid   (wb_valid),
    .wb_idx     (wb_idx),
    .wb_val     (wb_val),
    .flush      (flush)
  );

  assign rf_rs1_val = rf[rf_rs1_idx];
  assign rf_rs2_val = rf[rf_rs2_idx];

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Called right after a falling edge; returns on the falling edge after the transfer.
  task automatic send(input logic [31:0] instr, input logic [31:0] pc);
    int waited;
    waited = 0;
    fetched.valid      = 1'b1;
    fetched.data.instr = instr;
    fetched.data.pc    = pc;
    #1;
    while (!fetched.ready && waited < 20) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (!fetched.ready) chk("send_timeout", 32'(fetched.ready), 32'd1);
    @(negedge clk);
    fetched.valid = 1'b0;
  endtask

  task automatic send_check(input string tag, input logic [31:0] instr,
                            input instr_op op, input logic [31:0] imm);
    send(instr, 32'h400);
    chk({tag, "_valid"}, 32'(decoded.valid), 32'd1);
    chk({tag, "_op"}, 32'(decoded.data.op), 32'(op));
    chk({tag, "_imm"}, decoded.data.imm, imm);
  endtask

  initial begin
    logic exp_rdy;
    rst = 1'b1;
    flush = 1'b0;
    wb_valid = 1'b0;
    wb_idx = '0;
    wb_val = '0;
    fetched.valid = 1'b0;
    fetched.data = '0;
    decoded.ready = 1'b0;
    for (int i = 0; i < 32; i++) rf[i] = 32'h1000 + 32'(i);
    rf[0] = 32'hDEADBEEF;

    // reset state
    #12;
    chk("rst_valid", 32'(decoded.valid), 32'd0);
    chk("rst_ready", 32'(fetched.ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // ADDI x1,x0,5 held under backpressure
    send(32'h00500093, 32'h100);
    chk("addi_valid", 32'(decoded.valid), 32'd1);
    chk("addi_op", 32'(decoded.data.op), 32'(INSTR_OP_IMM));
    chk("addi_rd", 32'(decoded.data.rd), 32'd1);
    chk("addi_imm", decoded.data.imm, 32'd5);
    chk("addi_rs1", decoded.data.rs1_val, 32'd0);
    chk("addi_pc", decoded.data.pc, 32'h100);
    chk("addi_illegal", 32'(decoded.data.illegal), 32'd0);
`ifdef DECODE_SKID_EN
    exp_rdy = 1'b1;
`else
    exp_rdy = 1'b0;
`endif
    chk("addi_stall_ready", 32'(fetched.ready), 32'(exp_rdy));
    @(negedge clk);
    chk("addi_hold_valid", 32'(decoded.valid), 32'd1);
    chk("addi_hold_imm", decoded.data.imm, 32'd5);
    decoded.ready = 1'b1;
    @(negedge clk);
    chk("addi_drained", 32'(decoded.valid), 32'd0);

    // SUB x3,x1,x2 with write-back bypass during a 3-cycle stall
    decoded.ready = 1'b0;
    rf[1] = 32'd10;
    rf[2] = 32'd3;
    send(32'h402081B3, 32'h104);
    chk("sub_op", 32'(decoded.data.op), 32'(INSTR_OP));
    chk("sub_funct3", 32'(decoded.data.funct3), 32'd0);
    chk("sub_rd", 32'(decoded.data.rd), 32'd3);
    chk("sub_imm", decoded.data.imm, 32'h402);
    chk("sub_rs1", decoded.data.rs1_val, 32'd10);
    chk("sub_rs2", decoded.data.rs2_val, 32'd3);
    wb_valid = 1'b1;
    wb_idx = 5'd1;
    wb_val = 32'd7;
    rf[1] = 32'd7;
    @(negedge clk);
    wb_valid = 1'b0;
    chk("sub_wb_rs1", decoded.data.rs1_val, 32'd7);
    chk("sub_wb_rs2", decoded.data.rs2_val, 32'd3);
    wb_valid = 1'b1;
    wb_idx = 5'd0;
    wb_val = 32'd99;
    @(negedge clk);
    wb_valid = 1'b0;
    chk("sub_x0_rs1", decoded.data.rs1_val, 32'd7);
    chk("sub_x0_rs2", decoded.data.rs2_val, 32'd3);
    @(negedge clk);
    chk("sub_stall_valid", 32'(decoded.valid), 32'd1);
    chk("sub_stall_imm", decoded.data.imm, 32'h402);
    decoded.ready = 1'b1;
    @(negedge clk);
    chk("sub_drained", 32'(decoded.valid), 32'd0);

    // ADD x4,x5,x6 with write-back to x5 in the accept cycle
    decoded.ready = 1'b0;
    rf[5] = 32'h11;
    rf[6] = 32'h66;
    wb_valid = 1'b1;
    wb_idx = 5'd5;
    wb_val = 32'h55;
    send(32'h00628233, 32'h200);
    wb_valid = 1'b0;
    rf[5] = 32'h55;
    chk("add_rs1_bypass", decoded.data.rs1_val, 32'h55);
    chk("add_rs2", decoded.data.rs2_val, 32'h66);
    chk("add_rd", 32'(decoded.data.rd), 32'd4);
    decoded.ready = 1'b1;
    @(negedge clk);

    // immediate formats
    send_check("addi_neg", 32'hFFF00093, INSTR_OP_IMM, 32'hFFFFFFFF);
    send_check("lw",       32'hFFE12083, OP_LOAD,      32'hFFFFFFFE);
    send_check("lui",      32'h123452B7, OP_LUI,       32'h12345000);
    send_check("auipc",    32'h00001097, OP_AUIPC,     32'h00001000);
    send_check("sw",       32'hFE20AE23, OP_STORE,     32'hFFFFFFFC);
    send_check("beq",      32'hFE000CE3, OP_BRANCH,    32'hFFFFFFF8);
    send_check("jal",      32'h001000EF, OP_JAL,       32'h00000800);
    send_check("jalr",     32'h00008067, OP_JALR,      32'h00000000);
    send_check("ecall",    32'h00000073, OP_SYSTEM,    32'h00000000);

    // illegal words
    send_check("ill_zero", 32'h00000000, OP_NONE, 32'h0);
    chk("ill_zero_flag", 32'(decoded.data.illegal), 32'd1);
    send_check("ill_7f", 32'hFFFFFFFF, OP_NONE, 32'h0);
    chk("ill_7f_flag", 32'(decoded.data.illegal), 32'd1);
    chk("ill_7f_rd", 32'(decoded.data.rd), 32'd0);
    send_check("ill_lowbits", 32'h00500090, OP_NONE, 32'h0);
    chk("ill_lowbits_flag", 32'(decoded.data.illegal), 32'd1);
    send_check("ill_fence", 32'h0000000F, OP_NONE, 32'h0);
    chk("ill_fence_flag", 32'(decoded.data.illegal), 32'd1);
    @(negedge clk);

    // 8 back-to-back with ready held high
    decoded.ready = 1'b1;
    for (int i = 0; i <= 8; i++) begin
      if (i > 0) begin
        chk("stream_valid", 32'(decoded.valid), 32'd1);
        chk("stream_imm", decoded.data.imm, 32'(i + 9));
      end
      if (i < 8) begin
        fetched.valid      = 1'b1;
        fetched.data.instr = (32'(i + 10) << 20) | 32'h093;
        fetched.data.pc    = 32'h800 + 32'(i * 4);
        @(negedge clk);
      end else begin
        fetched.valid = 1'b0;
      end
    end
    @(negedge clk);

    // ready toggling 1/0 with a continuously offered stream
    sent = 0;
    got = 0;
    for (int cyc = 0; cyc < 80 && got < 8; cyc++) begin
      decoded.ready      = (cyc % 2) == 0;
      fetched.valid      = (sent < 8);
      fetched.data.instr = (32'(sent + 32) << 20) | 32'h093;
      fetched.data.pc    = 32'(sent);
      #1;
      if (decoded.valid && decoded.ready) begin
        if (exp_q.size() > 0) exp_v = exp_q.pop_front();
        else exp_v = 32'hFFFFFFFF;
        chk("toggle_data", decoded.data.imm, exp_v);
        got++;
      end
      if (fetched.valid && fetched.ready) begin
        exp_q.push_back(32'(sent + 32));
        sent++;
      end
      @(negedge clk);
    end
    fetched.valid = 1'b0;
    chk("toggle_count", 32'(got), 32'd8);
    chk("toggle_left", 32'(exp_q.size()), 32'd0);
    decoded.ready = 1'b1;
    @(negedge clk);
    chk("toggle_no_dup", 32'(decoded.valid), 32'd0);

    // flush with the pipeline full, while a new word is offered
    decoded.ready = 1'b0;
    send(32'h04000093, 32'h900);
`ifdef DECODE_SKID_EN
    send(32'h05000093, 32'h904);
`endif
    flush = 1'b1;
    decoded.ready = 1'b1;
    fetched.valid = 1'b1;
    fetched.data.instr = 32'h07700093;
    fetched.data.pc = 32'h908;
    #1;
    chk("flush_ready", 32'(fetched.ready), 32'd0);
    @(negedge clk);
    flush = 1'b0;
    fetched.valid = 1'b0;
    chk("flush_valid", 32'(decoded.valid), 32'd0);
    @(negedge clk);
    chk("flush_not_accepted", 32'(decoded.valid), 32'd0);

    // async reset mid-stream
    decoded.ready = 1'b0;
    send(32'h00500093, 32'hA00);
    chk("pre_rst_valid", 32'(decoded.valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(decoded.valid), 32'd0);
    chk("async_rst_ready", 32'(fetched.ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", 32'(decoded.valid), 32'd0);
    send(32'h00500093, 32'hB00);
    chk("post_rst_imm", decoded.data.imm, 32'd5);
    chk("post_rst_pc", decoded.data.pc, 32'hB00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
